proc_cmd_sequencer: RTL and testbench

Feeds instructions to processor_no_mem and sequences its run/done handshake. Instruction words come from a host/loader port and are buffered in a small FIFO. Each word is issued to the core with a one-cycle run pulse, and the block waits for done. It counts retired instructions and flags a hung core with a timeout. The block sits between the loader or bench and the core's command/run/done pins.

---
 rtl/proc_ctrl_pkg.sv | 25 ++
 rtl/cmd_fifo.sv | 64 ++++++
 rtl/proc_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_proc_cmd_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - shared sequencer states and RV32I opcode constants
package proc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERROR = 2'd3
    } seq_state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;

    function automatic logic [6:0] opcode_of(input logic [31:0] insn);
        return insn[6:0];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - instruction word FIFO with flush and occupancy count
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         s_tdata,
    input  logic                     s_tvalid,
    output logic [WIDTH-1:0]         m_tdata,
    input  logic                     m_tready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push;
    logic             pop;

    // full is judged on the registered count, so a same-cycle pop never frees a slot early
    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = s_tvalid && !full;
    assign pop     = m_tready && !empty;
    assign m_tdata = mem[rd_ptr];
    assign level   = count;

    // storage array; contents need no reset because count qualifies every read
    always_ff @(posedge clk) begin
        if (reset && push && !flush) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // pointers and occupancy; flush beats any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + LW'(1);
            end else if (pop && !push) begin
                count <= count - LW'(1);
            end
        end
    end

endmodule

// File: rtl/proc_cmd_sequencer.sv
// rtl/proc_cmd_sequencer.sv - buffers instruction words and sequences run/done with the core
module proc_cmd_sequencer
    import proc_ctrl_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     clear_err,
    output logic [31:0]              command,
    output logic                     run,
    input  logic                     done,
    output logic                     busy,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         retired
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    seq_state_t     state;
    seq_state_t     next_state;
    logic [TW-1:0]  timer;
    logic [31:0]    head;
    logic           pop;
    logic           fifo_flush;
    logic           fifo_full;
    logic           fifo_empty;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (fifo_flush),
        .s_tdata  (in_data),
        .s_tvalid (in_valid),
        .m_tdata  (head),
        .m_tready (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign in_ready = !fifo_full;
    assign run      = (state == ISSUE);
    assign busy     = (state != IDLE);
    assign err      = (state == ERROR);

    // next-state and pop decision; a flush in the same cycle suppresses the pop so the word is dropped, not issued
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        fifo_flush = flush;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty && !flush) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (done) begin
                    next_state = IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    next_state = ERROR;
                end
            end
            ERROR: begin
                if (clear_err) begin
                    next_state = IDLE;
                    fifo_flush = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // command latch: captured only on a pop and held through IDLE and ERROR
    always_ff @(posedge clk) begin
        if (!reset) begin
            command <= '0;
        end else if (pop) begin
            command <= head;
        end
    end

    // wait timer restarts in ISSUE and counts every WAIT cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer <= '0;
        end else if (state == ISSUE) begin
            timer <= '0;
        end else if (state == WAIT) begin
            timer <= timer + TW'(1);
        end
    end

    // retired count, wrapping; done is only honoured while waiting
    always_ff @(posedge clk) begin
        if (!reset) begin
            retired <= '0;
        end else if (state == WAIT && done) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_proc_cmd_sequencer.sv
// tb/tb_proc_cmd_sequencer.sv - scoreboard bench for proc_cmd_sequencer with a behavioural core
module tb_proc_cmd_sequencer;
    import proc_ctrl_pkg::*;

    localparam int T = 16;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset, enable, in_valid, in_ready, flush, clear_err, run, done, busy, err;
    logic [31:0] in_data, command;
    logic [3:0]  level;
    logic [15:0] retired;

    typedef struct { logic [31:0] word; int lat; } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int in_lat;
    int core_lat = 0;
    int start_cnt = 0;
    int exp_ret = 0;
    int core_x [32];

    proc_cmd_sequencer #(.DEPTH(D), .TIMEOUT(T), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .clear_err(clear_err), .command(command),
        .run(run), .done(done), .busy(busy), .err(err), .level(level), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard: accepted words enter the model queue, each run pops and checks the head
    initial begin : monitor
        exp_t e;
        bit   inflight = 0;
        bit   in_err = 0;
        int   cyc = 0;
        int   cur_lat = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                inflight = 0;
                in_err   = 0;
                exp_ret  = 0;
            end else begin
                if (inflight) begin
                    cyc++;
                    if (cur_lat >= 1 && cur_lat <= T) begin
                        if (cyc == cur_lat + 1) begin
                            exp_ret++;
                            check("done_busy", busy, 0);
                            check("done_err", err, 0);
                            check("done_retired", retired, 16'(exp_ret));
                            inflight = 0;
                        end
                    end else if (cyc == T) begin
                        check("pre_timeout_err", err, 0);
                        check("pre_timeout_busy", busy, 1);
                    end else if (cyc == T + 1) begin
                        check("timeout_err", err, 1);
                        in_err   = 1;
                        inflight = 0;
                    end
                end
                if (run) begin
                    check("run_while_busy", inflight || in_err, 0);
                    check("run_without_word", exp_q.size() == 0, 0);
                    if (exp_q.size() != 0 && !inflight && !in_err) begin
                        e = exp_q.pop_front();
                        check("command", command, e.word);
                        inflight  = 1;
                        cyc       = 0;
                        cur_lat   = e.lat;
                        core_lat  = e.lat;
                        start_cnt = start_cnt + 1;
                    end
                end
                if (flush || (clear_err && in_err)) begin
                    exp_q.delete();
                    if (clear_err) in_err = 0;
                end else if (in_valid && in_ready) begin
                    exp_q.push_back('{word: in_data, lat: in_lat});
                end
            end
        end
    end

    task automatic core_exec(input logic [31:0] c);
        int a, b, imm;
        a   = core_x[c[19:15]];
        b   = core_x[c[24:20]];
        imm = int'($signed(c[31:20]));
        if (c[11:7] != 5'd0 && c[14:12] == 3'b000) begin
            if (opcode_of(c) == OP_IMM) core_x[c[11:7]] = a + imm;
            else if (opcode_of(c) == OP) core_x[c[11:7]] = c[30] ? a - b : a + b;
        end
    endtask

    // Core model: executes the issued word and raises done lat cycles after run (lat 0 = never)
    initial begin : core
        int seen = 0;
        int d = 0;
        int j = 0;
        bit act = 0;
        done = 1'b0;
        for (int i = 0; i < 32; i++) core_x[i] = 0;
        forever begin
            tick();
            if (seen != start_cnt) begin
                seen = start_cnt;
                d    = core_lat;
                act  = (core_lat != 0);
                j    = 0;
                core_exec(command);
            end
            if (act) begin
                j++;
                done = (j == d);
                if (j == d) act = 0;
            end else begin
                done = 1'b0;
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input int lat);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        in_lat   = lat;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        check("push_bound", n < 300, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((busy || level != 0) && n < bound) begin
            clear_err = err;
            tick();
            n++;
        end
        clear_err = 1'b0;
        check("drain_bound", n < bound, 1);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom();
        w[6:0] = ($urandom_range(0, 1) == 1) ? OP_IMM : OP;
        return w;
    endfunction

    function automatic int rand_lat();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 0;
        if (r == 1) return T + 1;
        if (r == 2) return T;
        return $urandom_range(1, 4);
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : host
        int n;
        reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; in_lat = 0;
        flush = 1'b0; clear_err = 1'b0;
        repeat (3) tick();
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_run", run, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_retired", retired, 0);
        check("rst_command", command, 0);
        reset = 1'b1;
        tick();

        // basic issue
        enable = 1'b1;
        push_word(32'h00A00093, 2);
        drain(100);
        check("t1_retired", retired, 1);
        check("t1_x1", core_x[1], 10);

        // stream of three
        push_word(32'hFFC00113, 1);
        push_word(32'h002081B3, 3);
        push_word(32'h40208233, 2);
        drain(200);
        check("t2_retired", retired, 4);
        check("t2_x3", core_x[3], 6);
        check("t2_x4", core_x[4], 14);

        // hung core, push while in error, then clear
        push_word(32'h00500313, 0);
        n = 0;
        while (!err && n < 100) begin tick(); n++; end
        check("t2a_err_bound", n < 100, 1);
        push_word(32'h00700393, 1);
        check("t2a_level_in_err", level, 1);
        check("t2a_no_run", run, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t2a_clr_err", err, 0);
        check("t2a_clr_busy", busy, 0);
        check("t2a_clr_level", level, 0);

        // full FIFO
        enable = 1'b0;
        for (int i = 0; i < D; i++) push_word(rand_insn(), $urandom_range(1, 3));
        in_valid = 1'b1; in_data = 32'h12345013; in_lat = 1;
        repeat (3) tick();
        check("t3_in_ready_full", in_ready, 0);
        check("t3_level_full", level, D);
        in_valid = 1'b0;
        enable = 1'b1;
        drain(500);
        check("t3_retired", retired, 12);

        // done coincident with the last timer value
        push_word(32'h00100293, T);
        drain(100);
        check("t4a_retired", retired, 13);
        check("t4a_err", err, 0);

        // simultaneous push and pop at level 3
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push_word(rand_insn(), 1);
        check("t4b_level_pre", level, 3);
        enable = 1'b1; in_valid = 1'b1; in_data = rand_insn(); in_lat = 1;
        tick();
        in_valid = 1'b0;
        check("t4b_level_same", level, 3);
        check("t4b_run", run, 1);
        drain(200);
        check("t4b_retired", retired, 17);

        // reset during WAIT
        enable = 1'b0;
        push_word(rand_insn(), 6);
        push_word(rand_insn(), 6);
        enable = 1'b1;
        n = 0;
        while (!run && n < 20) begin tick(); n++; end
        check("t5_run_bound", n < 20, 1);
        tick();
        tick();
        check("t5_busy_pre", busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t5_run", run, 0);
        check("t5_busy", busy, 0);
        check("t5_level", level, 0);
        check("t5_retired", retired, 0);
        check("t5_err", err, 0);
        repeat (8) tick();
        check("t5_late_done_retired", retired, 0);
        check("t5_late_done_busy", busy, 0);

        // randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            enable    = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 60) == 0);
            clear_err = err && ($urandom_range(0, 2) == 0);
            in_valid  = ($urandom_range(0, 2) == 0);
            in_data   = rand_insn();
            in_lat    = rand_lat();
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; clear_err = 1'b0; enable = 1'b1;
        drain(3000);
        check("rand_retired", retired, 16'(exp_ret));
        check("rand_level", level, 0);
        check("rand_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
